lookup3_stream: RTL

LOOKUP3_STREAM -- requirements
Module: lookup3_stream

---
 rtl/lookup3_stream.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lookup3_stream.sv
// Streaming Bob Jenkins lookup3 hasher (hashlittle / hashlittle2).
// Absorbs one 12-byte key word per cycle, then a one-cycle final mix.
module lookup3_stream #(
   parameter int LEN_W = 16,
   parameter int HASH2 = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [LEN_W-1:0] key_len,
   input  logic [31:0]      seed_c,
   input  logic [31:0]      seed_b,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [95:0]      s_data,
   output logic             hash_valid,
   input  logic             hash_ready,
   output logic [31:0]      hash_c,
   output logic [31:0]      hash_b
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ABSORB = 2'd1,
      FINAL  = 2'd2,
      OUT    = 2'd3
   } state_t;

   state_t           state_r, state_s;
   logic [31:0]      a_r, b_r, c_r;
   logic [31:0]      a_s, b_s, c_s;
   logic [LEN_W-1:0] rem_r, rem_s;
   logic [31:0]      hash_c_r, hash_c_s;
   logic [31:0]      hash_b_r, hash_b_s;

   logic [31:0]      init_s;
   logic [31:0]      cinit_s;
   logic [95:0]      add_s;
   logic [95:0]      mix_s;
   logic [95:0]      masked_s;
   logic [95:0]      fin_s;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Packed as {c, b, a}.
   function automatic logic [95:0] lk_mix(input logic [95:0] abc);
      logic [31:0] a, b, c;
      a = abc[31:0];
      b = abc[63:32];
      c = abc[95:64];
      a = a - c;  a = a ^ rotl(c, 4);  c = c + b;
      b = b - a;  b = b ^ rotl(a, 6);  a = a + c;
      c = c - b;  c = c ^ rotl(b, 8);  b = b + a;
      a = a - c;  a = a ^ rotl(c, 16); c = c + b;
      b = b - a;  b = b ^ rotl(a, 19); a = a + c;
      c = c - b;  c = c ^ rotl(b, 4);  b = b + a;
      return {c, b, a};
   endfunction

   function automatic logic [95:0] lk_final(input logic [95:0] abc);
      logic [31:0] a, b, c;
      a = abc[31:0];
      b = abc[63:32];
      c = abc[95:64];
      c = c ^ b;  c = c - rotl(b, 14);
      a = a ^ c;  a = a - rotl(c, 11);
      b = b ^ a;  b = b - rotl(a, 25);
      c = c ^ b;  c = c - rotl(b, 16);
      a = a ^ c;  a = a - rotl(c, 4);
      b = b ^ a;  b = b - rotl(a, 14);
      c = c ^ b;  c = c - rotl(b, 24);
      return {c, b, a};
   endfunction

   // Only called on the last word, where the remaining count is at most 12.
   function automatic logic [95:0] mask_key(input logic [95:0] d, input logic [3:0] n);
      logic [95:0] m;
      m = 96'd0;
      for (int i = 0; i < 12; i++) begin
         if (4'(i) < n) begin
            m[8*i +: 8] = d[8*i +: 8];
         end else begin
            m[8*i +: 8] = 8'd0;
         end
      end
      return m;
   endfunction

   assign init_s   = 32'hDEADBEEF + 32'(key_len) + seed_c;
   assign cinit_s  = (HASH2 != 0) ? (init_s + seed_b) : init_s;
   assign add_s    = {c_r + s_data[95:64], b_r + s_data[63:32], a_r + s_data[31:0]};
   assign mix_s    = lk_mix(add_s);
   assign masked_s = mask_key(s_data, rem_r[3:0]);
   assign fin_s    = lk_final({c_r, b_r, a_r});

   assign start_ready = (state_r == IDLE);
   assign s_ready     = (state_r == ABSORB);
   assign hash_valid  = (state_r == OUT);
   assign hash_c      = hash_c_r;
   assign hash_b      = hash_b_r;

   // Next-state and datapath update.
   always_comb begin
      state_s  = state_r;
      a_s      = a_r;
      b_s      = b_r;
      c_s      = c_r;
      rem_s    = rem_r;
      hash_c_s = hash_c_r;
      hash_b_s = hash_b_r;
      case (state_r)
         IDLE: begin
            if (start_valid) begin
               a_s   = init_s;
               b_s   = init_s;
               c_s   = cinit_s;
               rem_s = key_len;
               if (key_len == {LEN_W{1'b0}}) begin
                  hash_c_s = cinit_s;
                  hash_b_s = (HASH2 != 0) ? init_s : 32'd0;
                  state_s  = OUT;
               end else begin
                  state_s = ABSORB;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ABSORB: begin
            if (s_valid) begin
               if (rem_r > LEN_W'(12)) begin
                  a_s   = mix_s[31:0];
                  b_s   = mix_s[63:32];
                  c_s   = mix_s[95:64];
                  rem_s = rem_r - LEN_W'(12);
               end else begin
                  a_s     = a_r + masked_s[31:0];
                  b_s     = b_r + masked_s[63:32];
                  c_s     = c_r + masked_s[95:64];
                  state_s = FINAL;
               end
            end else begin
               state_s = ABSORB;
            end
         end
         FINAL: begin
            hash_c_s = fin_s[95:64];
            hash_b_s = (HASH2 != 0) ? fin_s[63:32] : 32'd0;
            state_s  = OUT;
         end
         OUT: begin
            if (hash_ready) begin
               state_s = IDLE;
            end else begin
               state_s = OUT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         a_r      <= 32'd0;
         b_r      <= 32'd0;
         c_r      <= 32'd0;
         rem_r    <= {LEN_W{1'b0}};
         hash_c_r <= 32'd0;
         hash_b_r <= 32'd0;
      end else begin
         state_r  <= state_s;
         a_r      <= a_s;
         b_r      <= b_s;
         c_r      <= c_s;
         rem_r    <= rem_s;
         hash_c_r <= hash_c_s;
         hash_b_r <= hash_b_s;
      end
   end

endmodule
